// File: rtl/rv_pkg.sv
// Shared writeback-stage definitions: result-source codes, load funct3 codes
// and default datapath widths.
package rv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int CNT_W_DEF = 64;

  typedef enum logic [1:0] {
    RESSRC_ALU = 2'b00,
    RESSRC_MEM = 2'b01,
    RESSRC_PC4 = 2'b10,
    RESSRC_IMM = 2'b11
  } ressrc_e;

  localparam logic [2:0] LD_LB  = 3'b000;
  localparam logic [2:0] LD_LH  = 3'b001;
  localparam logic [2:0] LD_LW  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;

endpackage

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB writeback bundle plus decode read ports and retire counter.
`default_nettype none
interface wb_stage_regfile_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
);
  logic             ValidW;
  logic             RegWriteW;
  logic [1:0]       ResultSrcW;
  logic [2:0]       LoadTypeW;
  logic [XLEN-1:0]  ALUResW;
  logic [XLEN-1:0]  ReadDataW;
  logic [4:0]       RdW;
  logic [XLEN-1:0]  ImmW;
  logic [XLEN-1:0]  PC4W;
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [XLEN-1:0]  RD1D;
  logic [XLEN-1:0]  RD2D;
  logic [XLEN-1:0]  ResultW;
  logic [CNT_W-1:0] InstRetW;

  modport master (
    output ValidW, RegWriteW, ResultSrcW, LoadTypeW, ALUResW, ReadDataW,
           RdW, ImmW, PC4W, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, InstRetW
  );

  modport slave (
    input  ValidW, RegWriteW, ResultSrcW, LoadTypeW, ALUResW, ReadDataW,
           RdW, ImmW, PC4W, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, InstRetW
  );
endinterface
`default_nettype wire

// File: rtl/wb_stage_regfile_load_extend.sv
// Load-data extraction: selects byte/halfword lane and sign/zero extends.
`default_nettype none
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      addr_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_i)
      2'd0:    byte_sel = data_i[7:0];
      2'd1:    byte_sel = data_i[15:8];
      2'd2:    byte_sel = data_i[23:16];
      default: byte_sel = data_i[31:24];
    endcase
    // Misaligned halfwords are not trapped; the low address bit is dropped.
    half_sel = addr_i[1] ? data_i[31:16] : data_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      LD_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LD_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      LD_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LD_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = data_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage_regfile.sv
// Writeback stage: result select, 32-entry register file with write bypass
// to the decode read ports, and retired-instruction counter.
`default_nettype none
module wb_stage_regfile
  import rv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  wb_stage_regfile_if.slave bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [CNT_W-1:0] instret_q;
  logic [CNT_W-1:0] instret_d;
  logic [XLEN-1:0]  load_data;
  logic [XLEN-1:0]  result;
  logic             we;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data_i   (bus.ReadDataW),
    .addr_i   (bus.ALUResW[1:0]),
    .funct3_i (bus.LoadTypeW),
    .data_o   (load_data)
  );

  always_comb begin
    case (ressrc_e'(bus.ResultSrcW))
      RESSRC_ALU: result = bus.ALUResW;
      RESSRC_MEM: result = load_data;
      RESSRC_PC4: result = bus.PC4W;
      default:    result = bus.ImmW;
    endcase
  end

  assign we = bus.ValidW & bus.RegWriteW & (bus.RdW != 5'd0);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[bus.RdW] <= result;
    end
  end

  // Same-cycle bypass lets decode see the value being written this cycle.
  function automatic logic [XLEN-1:0] read_port(input logic [4:0] rs);
    if (!Rst_n || rs == 5'd0) return '0;
    if (we && bus.RdW == rs)  return result;
    return regs_q[rs];
  endfunction

  assign bus.RD1D    = read_port(bus.Rs1D);
  assign bus.RD2D    = read_port(bus.Rs2D);
  assign bus.ResultW = result;

  always_comb begin
    instret_d = instret_q;
    if (bus.ValidW) instret_d = instret_q + CNT_W'(1);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign bus.InstRetW = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_regfile.sv
// Randomized + directed bench for wb_stage_regfile against an array-based model.
`default_nettype none
module tb_wb_stage_regfile;
  import rv_pkg::*;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  wb_stage_regfile_if #(.XLEN(32), .CNT_W(64)) bus ();

  wb_stage_regfile dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  logic [31:0] mreg [32];
  logic [63:0] mcnt;
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_load();
    logic [31:0] w, v;
    w = bus.ReadDataW;
    case (bus.LoadTypeW)
      LD_LB, LD_LBU: begin
        v = (w >> (8 * int'(bus.ALUResW[1:0]))) & 32'hFF;
        if (bus.LoadTypeW == LD_LB && v >= 32'd128) v = v - 32'd256;
      end
      LD_LH, LD_LHU: begin
        v = (w >> (16 * int'(bus.ALUResW[1]))) & 32'hFFFF;
        if (bus.LoadTypeW == LD_LH && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] m_result();
    case (bus.ResultSrcW)
      2'b00:   return bus.ALUResW;
      2'b01:   return m_load();
      2'b10:   return bus.PC4W;
      default: return bus.ImmW;
    endcase
  endfunction

  function automatic bit m_we();
    return bus.ValidW && bus.RegWriteW && bus.RdW != 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (!Rst_n || rs == 5'd0) return 32'd0;
    if (m_we() && bus.RdW == rs) return m_result();
    return mreg[rs];
  endfunction

  task automatic set_in(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] lt, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] pc4,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.ValidW = v;    bus.RegWriteW = rw; bus.ResultSrcW = src;
    bus.LoadTypeW = lt; bus.ALUResW = alu; bus.ReadDataW = rdata;
    bus.RdW = rd;      bus.ImmW = imm;     bus.PC4W = pc4;
    bus.Rs1D = rs1;    bus.Rs2D = rs2;
    #1;
  endtask

  task automatic check_comb(input string tag);
    chk({tag, "_res"}, 64'(bus.ResultW), 64'(m_result()));
    chk({tag, "_rd1"}, 64'(bus.RD1D), 64'(m_read(bus.Rs1D)));
    chk({tag, "_rd2"}, 64'(bus.RD2D), 64'(m_read(bus.Rs2D)));
    chk({tag, "_cnt"}, bus.InstRetW, mcnt);
  endtask

  // Apply the architectural update at the edge, then return to mid-low phase.
  task automatic tick();
    @(posedge Clk);
    if (Rst_n) begin
      if (m_we()) mreg[bus.RdW] = m_result();
      if (bus.ValidW) mcnt = mcnt + 64'd1;
    end
    @(negedge Clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mcnt = 64'd0;
  endtask

  logic [63:0] cnt_snap;

  initial begin
    model_reset();
    Rst_n = 1'b0;
    set_in(0, 0, 2'b00, LD_LW, 0, 0, 0, 0, 0, 5'd1, 5'd2);
    chk("rst_rd1", 64'(bus.RD1D), 64'd0);
    chk("rst_cnt", bus.InstRetW, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Write x5, then reset asynchronously mid-cycle.
    set_in(1, 1, 2'b00, LD_LW, 32'hDEADBEEF, 0, 5'd5, 0, 0, 5'd0, 5'd0);
    tick();
    set_in(1, 0, 2'b00, LD_LW, 0, 0, 5'd0, 0, 0, 5'd5, 5'd5);
    chk("x5_written", 64'(bus.RD1D), 64'hDEADBEEF);
    Rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_rd1", 64'(bus.RD1D), 64'd0);
    chk("midrst_cnt", bus.InstRetW, 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("postrst_x5", 64'(bus.RD1D), 64'd0);

    // Ten valid non-writing instructions.
    for (int i = 0; i < 10; i++) begin
      set_in(1, 0, 2'b00, LD_LW, 32'h55, 0, 5'd9, 0, 0, 5'd9, 5'd0);
      tick();
    end
    #1;
    chk("cnt10", bus.InstRetW, 64'd10);

    // x0 guard.
    set_in(1, 1, 2'b00, LD_LW, 32'h1234, 0, 5'd0, 0, 0, 5'd0, 5'd0);
    chk("x0_same", 64'(bus.RD1D), 64'd0);
    tick();
    set_in(0, 0, 2'b00, LD_LW, 0, 0, 5'd0, 0, 0, 5'd0, 5'd0);
    chk("x0_after", 64'(bus.RD1D), 64'd0);

    // Load extraction on a fixed word.
    set_in(0, 0, 2'b01, LD_LB,  32'd3, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("lb3",  64'(bus.ResultW), 64'hFFFFFF80);
    set_in(0, 0, 2'b01, LD_LBU, 32'd3, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("lbu3", 64'(bus.ResultW), 64'h00000080);
    set_in(0, 0, 2'b01, LD_LH,  32'd2, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("lh2",  64'(bus.ResultW), 64'hFFFF80FF);
    set_in(0, 0, 2'b01, LD_LHU, 32'd0, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("lhu0", 64'(bus.ResultW), 64'h00007F01);
    set_in(0, 0, 2'b01, LD_LH,  32'd1, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("lh1",  64'(bus.ResultW), 64'h00007F01);
    set_in(0, 0, 2'b01, 3'b111, 32'd1, 32'h80FF7F01, 0, 0, 0, 0, 0);
    chk("ld_unlisted", 64'(bus.ResultW), 64'h80FF7F01);

    // Bypass on both ports.
    set_in(1, 1, 2'b00, LD_LW, 32'hA5A5A5A5, 0, 5'd7, 0, 0, 5'd7, 5'd7);
    chk("byp_rd1", 64'(bus.RD1D), 64'hA5A5A5A5);
    chk("byp_rd2", 64'(bus.RD2D), 64'hA5A5A5A5);
    tick();
    set_in(0, 0, 2'b00, LD_LW, 0, 0, 5'd0, 0, 0, 5'd7, 5'd7);
    chk("stored_rd1", 64'(bus.RD1D), 64'hA5A5A5A5);
    chk("stored_rd2", 64'(bus.RD2D), 64'hA5A5A5A5);

    // Result mux: PC+4 and immediate.
    set_in(0, 0, 2'b10, LD_LW, 32'h9, 0, 0, 32'h12345000, 32'h104, 0, 0);
    chk("mux_pc4", 64'(bus.ResultW), 64'h104);
    set_in(0, 0, 2'b11, LD_LW, 32'h9, 0, 0, 32'h12345000, 32'h104, 0, 0);
    chk("mux_imm", 64'(bus.ResultW), 64'h12345000);

    // Bubble must not write or count.
    set_in(1, 1, 2'b00, LD_LW, 32'h33, 0, 5'd3, 0, 0, 0, 0);
    tick();
    #1;
    cnt_snap = bus.InstRetW;
    set_in(0, 1, 2'b00, LD_LW, 32'hBAD, 0, 5'd3, 0, 0, 5'd3, 5'd0);
    tick();
    set_in(0, 0, 2'b00, LD_LW, 0, 0, 5'd0, 0, 0, 5'd3, 5'd0);
    chk("bubble_x3", 64'(bus.RD1D), 64'h33);
    chk("bubble_cnt", bus.InstRetW, cnt_snap);

    // Counter wrap from a preloaded near-max value.
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    release dut.instret_q;
    mcnt = 64'hFFFF_FFFF_FFFF_FFFE;
    set_in(1, 0, 2'b00, LD_LW, 0, 0, 5'd0, 0, 0, 0, 0);
    tick();
    #1;
    chk("cnt_max", bus.InstRetW, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    #1;
    chk("cnt_wrap", bus.InstRetW, 64'd0);

    // Randomized traffic; read addresses lean towards the write address.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd, rs1, rs2;
      rd  = 5'($urandom_range(0, 31));
      rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      set_in(1'($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom),
             3'($urandom), $urandom, $urandom, rd, $urandom, $urandom, rs1, rs2);
      check_comb("rnd");
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
